// File: rtl/game_pkg.sv
// Shared game definitions: global STATE bus codes,
// default timer constants and a saturating score helper.
package game_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0000,
    ST_WAIT   = 4'b0001,
    ST_ANSWER = 4'b0011,
    ST_DRAW   = 4'b0110,
    ST_GOOD   = 4'b1000,
    ST_OUCH   = 4'b1001,
    ST_WIN    = 4'b1010,
    ST_LOSE   = 4'b1011
  } state_e;

  localparam int TICK_DIV_DEF     = 5_000_000;
  localparam int ANS_TICKS_DEF    = 50;
  localparam int RESULT_TICKS_DEF = 20;
  localparam int WIN_SCORE_DEF    = 3;

  function automatic logic [3:0] sat_inc(
    input logic [3:0] v
  );
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Tick divider: counts 0..TICK_DIV-1 while en is high.
// Ports: CLK, RST (async high), clr, en in; tick out.
module tick_timer #(
  parameter int TICK_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt_q;

  assign tick = en && (cnt_q == W'(TICK_DIV - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/round_ctrl.sv
// Round sequencer: opens a timed answer window, judges
// 1P/2P answers and tracks scores up to WIN_SCORE.
// Ports: CLK, RST, OK, NUM, ANS_*, NEW_GAME in;
// STATE, TARGET, ANS_EN, TIME_LEFT, SCORE_1P/2P out.
module round_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int ANS_TICKS    = ANS_TICKS_DEF,
  parameter int RESULT_TICKS = RESULT_TICKS_DEF,
  parameter int WIN_SCORE    = WIN_SCORE_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       OK,
  input  logic [3:0] NUM,
  input  logic       ANS_1P_VALID,
  input  logic       ANS_1P_CORRECT,
  input  logic       ANS_2P_VALID,
  input  logic       ANS_2P_CORRECT,
  input  logic       NEW_GAME,
  output logic [3:0] STATE,
  output logic [3:0] TARGET,
  output logic       ANS_EN,
  output logic [6:0] TIME_LEFT,
  output logic [3:0] SCORE_1P,
  output logic [3:0] SCORE_2P
);

  state_e     state_q, state_d;
  logic [3:0] target_q, target_d;
  logic [6:0] tleft_q, tleft_d;
  logic [3:0] s1_q, s1_d;
  logic [3:0] s2_q, s2_d;
  logic [7:0] hold_q, hold_d;
  logic       ans_en_q;
  logic       tick;
  logic       tmr_en;
  logic       tmr_clr;
  logic       in_result;

  assign in_result = (state_q == ST_DRAW) ||
                     (state_q == ST_GOOD) ||
                     (state_q == ST_OUCH);
  assign tmr_en  = (state_q == ST_ANSWER) || in_result;
  // Fresh divider phase on every state entry.
  assign tmr_clr = (state_d != state_q);

  tick_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_tmr (
    .CLK (CLK),
    .RST (RST),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tick(tick)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    tleft_d  = tleft_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    hold_d   = hold_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (OK && (NUM != 4'd0)) begin
          target_d = NUM;
          tleft_d  = 7'(ANS_TICKS);
          state_d  = ST_ANSWER;
        end
      end
      ST_ANSWER: begin
        if (tick && (tleft_q != 7'd0)) begin
          tleft_d = tleft_q - 7'd1;
        end
        // Answers outrank the timeout in the same cycle.
        if (ANS_1P_VALID && ANS_2P_VALID) begin
          if (ANS_1P_CORRECT == ANS_2P_CORRECT) begin
            state_d = ST_DRAW;
          end else if (ANS_1P_CORRECT) begin
            state_d = ST_GOOD;
            s1_d    = sat_inc(s1_q);
          end else begin
            state_d = ST_OUCH;
            s2_d    = sat_inc(s2_q);
          end
        end else if (ANS_1P_VALID) begin
          if (ANS_1P_CORRECT) begin
            state_d = ST_GOOD;
            s1_d    = sat_inc(s1_q);
          end else begin
            state_d = ST_OUCH;
            s2_d    = sat_inc(s2_q);
          end
        end else if (ANS_2P_VALID) begin
          if (ANS_2P_CORRECT) begin
            state_d = ST_OUCH;
            s2_d    = sat_inc(s2_q);
          end else begin
            state_d = ST_GOOD;
            s1_d    = sat_inc(s1_q);
          end
        end else if (tick && (tleft_q == 7'd1)) begin
          state_d = ST_DRAW;
        end
      end
      ST_DRAW, ST_GOOD, ST_OUCH: begin
        if (tick) begin
          if (hold_q == 8'(RESULT_TICKS - 1)) begin
            if (s1_q >= 4'(WIN_SCORE)) begin
              state_d = ST_WIN;
            end else if (s2_q >= 4'(WIN_SCORE)) begin
              state_d = ST_LOSE;
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (NEW_GAME) begin
          state_d  = ST_IDLE;
          s1_d     = 4'd0;
          s2_d     = 4'd0;
          target_d = 4'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) begin
      hold_d = 8'd0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      target_q <= 4'd0;
      tleft_q  <= 7'd0;
      s1_q     <= 4'd0;
      s2_q     <= 4'd0;
      hold_q   <= 8'd0;
      ans_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      tleft_q  <= tleft_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      hold_q   <= hold_d;
      ans_en_q <= (state_d == ST_ANSWER);
    end
  end

  assign STATE     = state_q;
  assign TARGET    = target_q;
  assign ANS_EN    = ans_en_q;
  assign TIME_LEFT = tleft_q;
  assign SCORE_1P  = s1_q;
  assign SCORE_2P  = s2_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with small timer values:
// TICK_DIV=4, ANS_TICKS=5, RESULT_TICKS=3, WIN_SCORE=2.
module tb_round_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       OK = 1'b0;
  logic [3:0] NUM = 4'd0;
  logic       V1 = 1'b0;
  logic       C1 = 1'b0;
  logic       V2 = 1'b0;
  logic       C2 = 1'b0;
  logic       NEW_GAME = 1'b0;
  logic [3:0] STATE;
  logic [3:0] TARGET;
  logic       ANS_EN;
  logic [6:0] TIME_LEFT;
  logic [3:0] SCORE_1P;
  logic [3:0] SCORE_2P;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  round_ctrl #(
    .TICK_DIV    (4),
    .ANS_TICKS   (5),
    .RESULT_TICKS(3),
    .WIN_SCORE   (2)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .OK            (OK),
    .NUM           (NUM),
    .ANS_1P_VALID  (V1),
    .ANS_1P_CORRECT(C1),
    .ANS_2P_VALID  (V2),
    .ANS_2P_CORRECT(C2),
    .NEW_GAME      (NEW_GAME),
    .STATE         (STATE),
    .TARGET        (TARGET),
    .ANS_EN        (ANS_EN),
    .TIME_LEFT     (TIME_LEFT),
    .SCORE_1P      (SCORE_1P),
    .SCORE_2P      (SCORE_2P)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic st(input string tag,
                    input logic [3:0] exp);
    chk(tag, 32'(STATE), 32'(exp));
  endtask

  task automatic sc(input string tag,
                    input logic [3:0] e1,
                    input logic [3:0] e2);
    chk({tag, "_s1"}, 32'(SCORE_1P), 32'(e1));
    chk({tag, "_s2"}, 32'(SCORE_2P), 32'(e2));
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic ans(input logic v1, input logic c1,
                     input logic v2, input logic c2);
    V1 = v1; C1 = c1; V2 = v2; C2 = c2;
    step();
    V1 = 0; C1 = 0; V2 = 0; C2 = 0;
  endtask

  initial begin
    step(2);
    st("rst_state", 4'h0);
    chk("rst_tgt", 32'(TARGET), 32'd0);
    chk("rst_tl", 32'(TIME_LEFT), 32'd0);
    chk("rst_en", 32'(ANS_EN), 32'd0);
    sc("rst", 0, 0);

    RST = 0; OK = 1; NUM = 4'd7;
    st("t1_idle", 4'h0);
    step();
    st("t1_wait", 4'h1);
    step();
    st("t1_ans", 4'h3);
    chk("t1_tgt", 32'(TARGET), 32'd7);
    chk("t1_tl", 32'(TIME_LEFT), 32'd5);
    chk("t1_en", 32'(ANS_EN), 32'd1);

    ans(1, 1, 0, 0);
    st("t2_good", 4'h8);
    sc("t2", 1, 0);
    chk("t2_en", 32'(ANS_EN), 32'd0);
    step(11);
    st("t2_hold", 4'h8);
    step();
    st("t2_wait", 4'h1);

    step();
    st("t3_ans", 4'h3);
    ans(1, 0, 1, 1);
    st("t3_ouch", 4'h9);
    sc("t3a", 1, 1);
    step(12);
    st("t3_wait", 4'h1);
    step();
    ans(1, 1, 1, 1);
    st("t3_draw", 4'h6);
    sc("t3b", 1, 1);
    step(12);
    st("t3_wait2", 4'h1);
    step();
    st("t4_ans", 4'h3);

    step(4);
    chk("t4_tl4", 32'(TIME_LEFT), 32'd4);
    step(12);
    chk("t4_tl1", 32'(TIME_LEFT), 32'd1);
    step(3);
    st("t4_last", 4'h3);
    step();
    st("t4_draw", 4'h6);
    chk("t4_tl0", 32'(TIME_LEFT), 32'd0);
    sc("t4", 1, 1);
    step(12);
    st("t4_wait", 4'h1);
    step();
    step(19);
    st("t4_edge", 4'h3);
    ans(1, 0, 0, 0);
    st("t4_ouch", 4'h9);
    sc("t4b", 1, 2);
    step(12);
    st("t5_lose", 4'hB);
    ans(1, 1, 0, 0);
    st("t5_lose_hold", 4'hB);
    sc("t5_lose", 1, 2);

    NUM = 4'd3;
    NEW_GAME = 1;
    step();
    NEW_GAME = 0;
    st("t5_ng_idle", 4'h0);
    sc("t5_ng", 0, 0);
    chk("t5_ng_tgt", 32'(TARGET), 32'd0);
    step(2);
    st("t5_ans", 4'h3);
    chk("t5_tgt", 32'(TARGET), 32'd3);
    ans(1, 1, 0, 0);
    st("t5_good1", 4'h8);
    step(12);
    st("t5_wait", 4'h1);
    step();
    ans(0, 0, 1, 0);
    st("t5_good2", 4'h8);
    sc("t5_g2", 2, 0);
    step(12);
    st("t5_win", 4'hA);
    NEW_GAME = 1;
    step();
    NEW_GAME = 0;
    st("t5_win_ng", 4'h0);
    sc("t5_win_ng", 0, 0);

    NUM = 4'd0;
    step();
    st("t6_wait", 4'h1);
    step(3);
    st("t6_num0", 4'h1);
    NUM = 4'd5;
    step();
    st("t6_ans", 4'h3);
    chk("t6_tgt", 32'(TARGET), 32'd5);
    NEW_GAME = 1;
    step();
    NEW_GAME = 0;
    st("t6_ng_ign", 4'h3);
    ans(1, 1, 0, 0);
    sc("t6", 1, 0);
    step(12);
    step();
    st("t6_ans2", 4'h3);
    step(2);
    #2;
    RST = 1;
    #1;
    st("t6_rst_state", 4'h0);
    chk("t6_rst_tgt", 32'(TARGET), 32'd0);
    chk("t6_rst_tl", 32'(TIME_LEFT), 32'd0);
    chk("t6_rst_en", 32'(ANS_EN), 32'd0);
    sc("t6_rst", 0, 0);
    step();
    RST = 0;
    step();
    st("t6_post", 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
